// File: rtl/game_dialog_char_src.sv
// game_dialog_char_src
//   Character source for a typewriter-style dialog box. For the character cell
//   and glyph line being scanned, it returns the 8-pixel glyph line of the
//   selected message. The message is revealed one character per REVEAL_FRAMES
//   frames, and the skip input can reveal it in full at once.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous reset, active low
//   char_xy          [4:0] column 0..31, [7:5] row 0..3
//   char_line        glyph line 0..15 within the cell
//   dialog_sel       0/7 = no dialog, 1..6 = message number
//   vblnk            vertical blank; its rising edge is the frame tick
//   skip             level; shows the whole message immediately
//   char_line_pixels glyph line, bit 7 = leftmost pixel (2-cycle latency)
//   reveal_done      1 while the whole message is visible (HOLD)
module game_dialog_char_src #(
  parameter int REVEAL_FRAMES = 2,
  parameter int TEXT_COLS     = 32,
  parameter int TEXT_ROWS     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  input  logic [3:0] char_line,
  input  logic [2:0] dialog_sel,
  input  logic       vblnk,
  input  logic       skip,
  output logic [7:0] char_line_pixels,
  output logic       reveal_done
);

  typedef enum logic [1:0] {IDLE, REVEAL, HOLD} state_t;

  localparam logic [7:0] CELLS      = 8'(TEXT_COLS * TEXT_ROWS);
  localparam logic [7:0] COLS8      = 8'(TEXT_COLS);
  localparam logic [3:0] ROWS4      = 4'(TEXT_ROWS);
  localparam logic [3:0] FRAME_LAST = 4'(REVEAL_FRAMES - 1);
  localparam logic [6:0] SPACE      = 7'h20;

  // Message text: each message occupies the first ten cells of row 0; the last
  // cell of every message carries a '*' marker. All other cells are spaces.
  function automatic logic [6:0] text_code(input logic [2:0] msg, input logic [6:0] idx);
    logic [79:0] s;
    int          i;
    s = "          ";
    case (msg)
      3'd1:    s = "HELLO!    ";
      3'd2:    s = "GO NOW    ";
      3'd3:    s = "A KEY     ";
      3'd4:    s = "LOOK HIGH ";
      3'd5:    s = "I WIN     ";
      3'd6:    s = "NO GO     ";
      default: s = "          ";
    endcase
    i = int'(idx);
    text_code = SPACE;
    if (idx == 7'd127)
      text_code = 7'h2A;
    else if (i < 10)
      text_code = s[8*(9-i) +: 7];
  endfunction

  // Font ROM: 8x8 glyphs drawn on lines 4..11 of the 16-line cell, top row in
  // the most significant byte. Codes without a glyph render blank.
  function automatic logic [7:0] font_line(input logic [6:0] code, input logic [3:0] line);
    logic [63:0] g;
    int          l;
    case (code)
      7'h21:   g = 64'h1818_1818_1800_1800; // !
      7'h2A:   g = 64'h0066_3CFF_3C66_0000; // *
      7'h41:   g = 64'h183C_6666_7E66_6600; // A
      7'h45:   g = 64'h7E60_607C_6060_7E00; // E
      7'h47:   g = 64'h3C66_606E_6666_3C00; // G
      7'h48:   g = 64'h6666_667E_6666_6600; // H
      7'h49:   g = 64'h3C18_1818_1818_3C00; // I
      7'h4B:   g = 64'h666C_7870_786C_6600; // K
      7'h4C:   g = 64'h6060_6060_6060_7E00; // L
      7'h4E:   g = 64'h6676_7E7E_6E66_6600; // N
      7'h4F:   g = 64'h3C66_6666_6666_3C00; // O
      7'h57:   g = 64'h6363_636B_7F77_6300; // W
      7'h59:   g = 64'h6666_663C_1818_1800; // Y
      default: g = 64'h0;
    endcase
    l = int'(line);
    font_line = 8'h00;
    if (l >= 4 && l <= 11)
      font_line = g[8*(11-l) +: 8];
  endfunction

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_reveal_cnt, w_reveal_nxt;
  logic [3:0]  r_frame_cnt, w_frame_nxt;
  logic [2:0]  r_sel_d;
  logic        r_vblnk_d;
  logic        r_done;
  logic [6:0]  r_code_p1;
  logic [3:0]  r_line_p1;
  logic [7:0]  r_pix_p2;

  logic [2:0]  w_sel;
  logic        w_sel_chg;
  logic        w_tick;
  logic [2:0]  w_row;
  logic [4:0]  w_col;
  logic [7:0]  w_idx;
  logic [6:0]  w_code;

  assign w_sel     = (dialog_sel == 3'd7) ? 3'd0 : dialog_sel;
  assign w_sel_chg = (w_sel != r_sel_d);
  assign w_tick    = vblnk & ~r_vblnk_d;
  assign w_row     = char_xy[7:5];
  assign w_col     = char_xy[4:0];
  assign w_idx     = ({5'd0, w_row} * COLS8) + {3'd0, w_col};

  always_comb begin
    w_state_nxt  = r_state;
    w_reveal_nxt = r_reveal_cnt;
    w_frame_nxt  = r_frame_cnt;
    case (r_state)
      IDLE: begin
        if (w_sel != 3'd0) begin
          w_state_nxt  = REVEAL;
          w_reveal_nxt = 8'd0;
          w_frame_nxt  = 4'd0;
        end
      end
      REVEAL, HOLD: begin
        // A message change outranks skip and ticks in the same cycle.
        if (w_sel_chg) begin
          w_state_nxt  = (w_sel == 3'd0) ? IDLE : REVEAL;
          w_reveal_nxt = 8'd0;
          w_frame_nxt  = 4'd0;
        end else if (skip || r_state == HOLD) begin
          w_state_nxt  = HOLD;
          w_reveal_nxt = CELLS;
        end else if (w_tick) begin
          if (r_frame_cnt >= FRAME_LAST) begin
            w_frame_nxt = 4'd0;
            if (r_reveal_cnt >= CELLS - 8'd1) begin
              w_reveal_nxt = CELLS;
              w_state_nxt  = HOLD;
            end else begin
              w_reveal_nxt = r_reveal_cnt + 8'd1;
            end
          end else begin
            w_frame_nxt = r_frame_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_code = text_code(r_sel_d, w_idx[6:0]);
    if (r_state == IDLE || {1'b0, w_row} >= ROWS4 || w_idx >= r_reveal_cnt)
      w_code = SPACE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_reveal_cnt <= 8'd0;
      r_frame_cnt  <= 4'd0;
      r_sel_d      <= 3'd0;
      r_vblnk_d    <= 1'b0;
      r_done       <= 1'b0;
      r_code_p1    <= 7'd0;
      r_line_p1    <= 4'd0;
      r_pix_p2     <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_reveal_cnt <= w_reveal_nxt;
      r_frame_cnt  <= w_frame_nxt;
      r_sel_d      <= w_sel;
      r_vblnk_d    <= vblnk;
      r_done       <= (w_state_nxt == HOLD);
      // stage 1: masked character code and glyph line
      r_code_p1    <= w_code;
      r_line_p1    <= char_line;
      // stage 2: font ROM output
      r_pix_p2     <= font_line(r_code_p1, r_line_p1);
    end
  end

  assign char_line_pixels = r_pix_p2;
  assign reveal_done      = r_done;

endmodule

// File: tb/tb_game_dialog_char_src.sv
module tb_game_dialog_char_src;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] char_xy = 8'h00;
  logic [3:0] char_line = 4'd0;
  logic [2:0] dialog_sel = 3'd0;
  logic       vblnk = 1'b0;
  logic       skip = 1'b0;
  logic [7:0] char_line_pixels;
  logic       reveal_done;

  int n_chk  = 0;
  int n_pass = 0;

  game_dialog_char_src #(
    .REVEAL_FRAMES(2),
    .TEXT_COLS(32),
    .TEXT_ROWS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .char_xy(char_xy),
    .char_line(char_line),
    .dialog_sel(dialog_sel),
    .vblnk(vblnk),
    .skip(skip),
    .char_line_pixels(char_line_pixels),
    .reveal_done(reveal_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      vblnk = 1'b1;
      step(1);
      vblnk = 1'b0;
      step(1);
    end
  endtask

  task automatic pix_at(input string tag, input logic [7:0] xy, input logic [3:0] ln,
                        input logic [7:0] exp);
    char_xy   = xy;
    char_line = ln;
    step(2);
    check_eq(tag, 32'(char_line_pixels), 32'(exp));
  endtask

  initial begin
    // reset state
    step(3);
    check_eq("rst_done", 32'(reveal_done), 32'd0);
    check_eq("rst_pix", 32'(char_line_pixels), 32'h00);
    rst = 1'b1;
    step(1);

    // idle: space glyph after two cycles
    pix_at("idle_space", 8'h00, 4'd5, 8'h00);

    // message 1 "HELLO!": reveal timing
    dialog_sel = 3'd1;
    step(1);
    pix_at("rev0_cell0", 8'h00, 4'd4, 8'h00);
    frames(6);
    pix_at("rev3_cell0_H", 8'h00, 4'd4, 8'h66);
    pix_at("rev3_cell1_E", 8'h01, 4'd4, 8'h7E);
    pix_at("rev3_cell2_L", 8'h02, 4'd4, 8'h60);
    pix_at("rev3_cell3_blank", 8'h03, 4'd4, 8'h00);
    check_eq("rev3_done", 32'(reveal_done), 32'd0);

    // advance to reveal_cnt=10, then skip
    frames(14);
    pix_at("rev10_cell5_bang", 8'h05, 4'd4, 8'h18);
    skip = 1'b1;
    step(1);
    skip = 1'b0;
    check_eq("skip_done", 32'(reveal_done), 32'd1);
    pix_at("skip_cell127_l7", 8'h7F, 4'd7, 8'hFF);
    pix_at("skip_cell127_l5", 8'h7F, 4'd5, 8'h66);

    // exact two-cycle latency
    pix_at("lat_pre", 8'h0A, 4'd4, 8'h00);
    char_xy = 8'h00;
    step(1);
    check_eq("lat_1cyc", 32'(char_line_pixels), 32'h00);
    step(1);
    check_eq("lat_2cyc", 32'(char_line_pixels), 32'h66);

    // message change 1 -> 3 ("A KEY") while in HOLD
    dialog_sel = 3'd3;
    step(1);
    check_eq("chg_done", 32'(reveal_done), 32'd0);
    pix_at("chg_cell0_blank", 8'h00, 4'd4, 8'h00);
    pix_at("chg_cell127_blank", 8'h7F, 4'd7, 8'h00);
    frames(2);
    pix_at("chg_cell0_A", 8'h00, 4'd4, 8'h18);
    pix_at("chg_cell2_blank", 8'h02, 4'd4, 8'h00);

    // saturation and row bound
    frames(300);
    check_eq("sat_done", 32'(reveal_done), 32'd1);
    pix_at("sat_cell127", 8'h7F, 4'd7, 8'hFF);
    pix_at("sat_cell2_K", 8'h02, 4'd4, 8'h66);
    pix_at("row5", 8'hA0, 4'd4, 8'h00);
    pix_at("row4_alias", 8'h80, 4'd4, 8'h00);
    pix_at("row7_alias", 8'hFF, 4'd7, 8'h00);

    // change and skip together: change wins, skip applies next cycle
    dialog_sel = 3'd4;
    skip = 1'b1;
    step(1);
    check_eq("prio_restart", 32'(reveal_done), 32'd0);
    step(1);
    skip = 1'b0;
    check_eq("prio_skip_next", 32'(reveal_done), 32'd1);
    pix_at("prio_cell0_L", 8'h00, 4'd4, 8'h60);

    // tick and skip together
    dialog_sel = 3'd5;
    step(1);
    check_eq("tks_restart", 32'(reveal_done), 32'd0);
    vblnk = 1'b1;
    skip  = 1'b1;
    step(1);
    vblnk = 1'b0;
    skip  = 1'b0;
    check_eq("tks_done", 32'(reveal_done), 32'd1);
    pix_at("tks_cell127", 8'h7F, 4'd7, 8'hFF);
    pix_at("tks_cell0_I", 8'h00, 4'd4, 8'h3C);
    step(2);

    // dialog_sel = 7 behaves as no dialog
    dialog_sel = 3'd7;
    step(1);
    check_eq("sel7_done", 32'(reveal_done), 32'd0);
    pix_at("sel7_blank", 8'h00, 4'd4, 8'h00);
    frames(4);
    pix_at("sel7_still_blank", 8'h00, 4'd4, 8'h00);

    // mid-reveal reset at reveal_cnt=50 with message 2 "GO NOW"
    dialog_sel = 3'd2;
    step(1);
    frames(100);
    pix_at("mid_cell5_W", 8'h05, 4'd4, 8'h63);
    rst = 1'b0;
    step(1);
    check_eq("mid_rst_done", 32'(reveal_done), 32'd0);
    check_eq("mid_rst_pix", 32'(char_line_pixels), 32'h00);
    rst = 1'b1;
    step(1);
    pix_at("mid_restart_blank", 8'h00, 4'd4, 8'h00);
    frames(2);
    pix_at("mid_restart_G", 8'h00, 4'd4, 8'h3C);
    pix_at("mid_restart_cell1", 8'h01, 4'd4, 8'h00);
    check_eq("mid_restart_done", 32'(reveal_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
